// File: rtl/router_pkg.sv
// router_pkg: flit type codes, output-port bit indices, input-buffer FSM states
// and the one-hot route legality test shared by the router blocks.
package router_pkg;
    localparam logic [1:0] HDR  = 2'b10;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b01;
    localparam int L = 0;
    localparam int E = 1;
    localparam int W = 2;
    localparam int S = 3;
    localparam int N = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DROP = 2'd2} state_t;
    function automatic logic is_onehot(input logic [N:0] v);
        return v != '0 && (v & (v - 1'b1)) == '0;
    endfunction
endpackage

// File: rtl/input_port_buffer_if.sv
// input_port_buffer_if: upstream link, route-compute, allocator and output
// signals of one router input port; master drives the port, slave is the buffer.
interface input_port_buffer_if #(parameter int FLIT_W = 8, parameter int CNT_W = 8);
    logic [FLIT_W-1:0] flit_in;
    logic [1:0]        type_in;
    logic              valid_in;
    logic              ready_out;
    logic [FLIT_W-1:0] hdr_to_rc;
    logic [4:0]        rc_onehot;
    logic [4:0]        req_out;
    logic              grant_in;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        type_out;
    logic              valid_out;
    logic [CNT_W-1:0]  drop_cnt;
    modport master(output flit_in, type_in, valid_in, rc_onehot, grant_in,
                   input ready_out, hdr_to_rc, req_out, flit_out, type_out, valid_out, drop_cnt);
    modport slave(input flit_in, type_in, valid_in, rc_onehot, grant_in,
                  output ready_out, hdr_to_rc, req_out, flit_out, type_out, valid_out, drop_cnt);
endinterface

// File: rtl/flit_fifo.sv
// flit_fifo: DEPTH-entry circular flit store with occupancy count; the front
// entry reads as zero while empty.
module flit_fifo #(parameter int DEPTH = 4, parameter int W = 10) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/input_port_buffer.sv
// input_port_buffer: buffers flits, latches the route of each legal header and
// holds the request until the tail is forwarded; drops unroutable and orphan flits.
module input_port_buffer
    import router_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 8,
    parameter int CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    input_port_buffer_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t            state;
    logic [N:0]        route;
    logic [FLIT_W+1:0] head;
    logic [FLIT_W-1:0] head_flit;
    logic [1:0]        head_type;
    logic              full, empty, pop, fwd, legal;
    flit_fifo #(.DEPTH(DEPTH), .W(FLIT_W + 2)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(bus.valid_in), .pop(pop),
        .din({bus.type_in, bus.flit_in}), .dout(head), .full(full), .empty(empty)
    );
    assign {head_type, head_flit} = head;
    assign legal         = is_onehot(bus.rc_onehot);
    assign bus.ready_out = !full;
    assign bus.hdr_to_rc = head_flit;
    assign bus.req_out   = state == ACTIVE ? route : '0;
    assign fwd           = state == ACTIVE && bus.grant_in && !empty;
    // a legal header waits at the front in IDLE until its route is latched
    assign pop = !empty && (state == IDLE ? (head_type != HDR || !legal) :
                            state == ACTIVE ? bus.grant_in : 1'b1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            route         <= '0;
            bus.flit_out  <= '0;
            bus.type_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.drop_cnt  <= '0;
        end else begin
            bus.valid_out <= fwd;
            if (fwd) begin
                bus.flit_out <= head_flit;
                bus.type_out <= head_type;
            end
            if (pop && !fwd && bus.drop_cnt != CNT_MAX) bus.drop_cnt <= bus.drop_cnt + CNT_W'(1);
            case (state)
                IDLE: if (!empty && head_type == HDR) begin
                    state <= legal ? ACTIVE : DROP;
                    route <= legal ? bus.rc_onehot : '0;
                end
                ACTIVE, DROP: if (pop && head_type == TAIL) begin
                    state <= IDLE;
                    route <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed scenarios plus a randomized packet stream
// checked against a packet-level model of forwarding and dropping.
module tb_input_port_buffer;
    import router_pkg::*;
    localparam int DEPTH = 4, FLIT_W = 8, CNT_W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_drop = 0;
    logic [4:0] rc_tab [16];

    input_port_buffer_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) bus ();
    input_port_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    // route compute stand-in: a per-destination lookup table
    assign bus.rc_onehot = rc_tab[bus.hdr_to_rc[3:0]];

    task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] f);
        bus.valid_in = v;
        bus.type_in  = t;
        bus.flit_in  = f;
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] f);
        drive(1'b1, t, f);
        @(negedge clk);
        drive(1'b0, BODY, 8'h00);
    endtask

    task automatic test_reset();
        drive(1'b0, BODY, 8'h00);
        bus.grant_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.req_out !== 5'b0 || bus.valid_out !== 1'b0 || bus.drop_cnt !== 8'd0 ||
            bus.flit_out !== 8'h00 || bus.type_out !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state: req=%b valid=%b drop=%0d flit=%h type=%b, want all zero",
                     bus.req_out, bus.valid_out, bus.drop_cnt, bus.flit_out, bus.type_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.ready_out !== 1'b1 || bus.hdr_to_rc !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b hdr_to_rc=%h, want 1 and 00", bus.ready_out, bus.hdr_to_rc);
        end
        exp_drop = 0;
    endtask

    task automatic test_basic();
        logic [4:0] er [7];
        logic       ev [7];
        logic [7:0] ef [7];
        logic [1:0] et [7];
        er = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0};
        ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ef = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h55, 8'hAA, 8'h00};
        et = '{2'b00, 2'b00, 2'b00, HDR, BODY, TAIL, 2'b00};
        bus.grant_in = 1'b1;
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (bus.req_out !== er[c] || bus.valid_out !== ev[c] ||
                (ev[c] && (bus.flit_out !== ef[c] || bus.type_out !== et[c]))) begin
                n_bad++;
                $display("FAIL basic_cycle%0d: req=%b valid=%b flit=%h type=%b, want req=%b valid=%b flit=%h type=%b",
                         c, bus.req_out, bus.valid_out, bus.flit_out, bus.type_out, er[c], ev[c], ef[c], et[c]);
            end
            drive(c < 3, c == 0 ? HDR : c == 1 ? BODY : TAIL, c == 0 ? 8'h0C : c == 1 ? 8'h55 : 8'hAA);
            @(negedge clk);
        end
        bus.grant_in = 1'b0;
        n_cmp++;
        if (bus.drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL basic_drop: drop=%0d, want %0d", bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_hold();
        logic [7:0] ef [3];
        int idx = 0;
        ef = '{8'h0A, 8'h5A, 8'hA5};
        bus.grant_in = 1'b0;
        send(HDR, 8'h0A);
        send(BODY, 8'h5A);
        send(TAIL, 8'hA5);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (bus.req_out !== 5'b00010 || bus.valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: req=%b valid=%b, want 00010 and 0", c, bus.req_out, bus.valid_out);
            end
            @(negedge clk);
        end
        bus.grant_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                n_cmp++;
                if (idx >= 3 || bus.flit_out !== ef[idx]) begin
                    n_bad++;
                    $display("FAIL hold_drain%0d: flit=%h, want %h", idx, bus.flit_out, idx < 3 ? ef[idx] : 8'hxx);
                end
                idx++;
            end
        end
        bus.grant_in = 1'b0;
        n_cmp++;
        if (idx != 3 || bus.req_out !== 5'b0) begin
            n_bad++;
            $display("FAIL hold_end: flits=%0d req=%b, want 3 and 00000", idx, bus.req_out);
        end
    endtask

    task automatic test_drop();
        logic [1:0] t [4];
        logic [7:0] f [4];
        t = '{HDR, BODY, BODY, TAIL};
        f = '{8'h08, 8'h11, 8'h22, 8'h44};
        bus.grant_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (bus.req_out !== 5'b0 || bus.valid_out !== 1'b0) begin
                n_bad++;
                $display("FAIL drop_cycle%0d: req=%b valid=%b, want 00000 and 0", c, bus.req_out, bus.valid_out);
            end
            if (c < 4) drive(1'b1, t[c], f[c]);
            else drive(1'b0, BODY, 8'h00);
            @(negedge clk);
        end
        bus.grant_in = 1'b0;
        exp_drop += 4;
        n_cmp++;
        if (bus.drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL drop_count: drop=%0d, want %0d", bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_orphan();
        logic [1:0] t [3];
        logic [7:0] f [3];
        logic [7:0] ef [2];
        logic [4:0] prev_req = 5'b0;
        int idx = 0;
        t = '{BODY, HDR, TAIL};
        f = '{8'h33, 8'h0C, 8'h77};
        ef = '{8'h0C, 8'h77};
        bus.grant_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus.valid_out === 1'b1) begin
                n_cmp++;
                if (idx >= 2 || bus.flit_out !== ef[idx] || prev_req !== 5'b00001) begin
                    n_bad++;
                    $display("FAIL orphan_fwd%0d: flit=%h req=%b, want %h and 00001",
                             idx, bus.flit_out, prev_req, idx < 2 ? ef[idx] : 8'hxx);
                end
                idx++;
            end
            prev_req = bus.req_out;
            if (c < 3) drive(1'b1, t[c], f[c]);
            else drive(1'b0, BODY, 8'h00);
            @(negedge clk);
        end
        bus.grant_in = 1'b0;
        exp_drop += 1;
        n_cmp++;
        if (idx != 2 || bus.drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL orphan_end: flits=%0d drop=%0d, want 2 and %0d", idx, bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_full();
        logic [7:0] ef [4];
        int idx = 0;
        ef = '{8'h01, 8'h02, 8'h03, 8'hEE};
        bus.grant_in = 1'b0;
        send(HDR, 8'h0A);
        send(BODY, 8'h01);
        send(BODY, 8'h02);
        send(BODY, 8'h03);
        drive(1'b1, TAIL, 8'hEE);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bus.ready_out !== 1'b0) begin
                n_bad++;
                $display("FAIL full_ready%0d: ready=%b, want 0", c, bus.ready_out);
            end
            if (c < 2) @(negedge clk);
        end
        bus.grant_in = 1'b1;
        @(negedge clk);
        bus.grant_in = 1'b0;
        n_cmp++;
        if (bus.valid_out !== 1'b1 || bus.flit_out !== 8'h0A || bus.ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL full_pop: valid=%b flit=%h ready=%b, want 1 0a 1", bus.valid_out, bus.flit_out, bus.ready_out);
        end
        @(negedge clk);
        drive(1'b0, BODY, 8'h00);
        n_cmp++;
        if (bus.ready_out !== 1'b0) begin
            n_bad++;
            $display("FAIL full_refill: ready=%b, want 0", bus.ready_out);
        end
        bus.grant_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                n_cmp++;
                if (idx >= 4 || bus.flit_out !== ef[idx]) begin
                    n_bad++;
                    $display("FAIL full_order%0d: flit=%h, want %h", idx, bus.flit_out, idx < 4 ? ef[idx] : 8'hxx);
                end
                idx++;
            end
        end
        bus.grant_in = 1'b0;
        n_cmp++;
        if (idx != 4 || bus.req_out !== 5'b0) begin
            n_bad++;
            $display("FAIL full_end: flits=%0d req=%b, want 4 and 00000", idx, bus.req_out);
        end
    endtask

    task automatic test_async_reset();
        bus.grant_in = 1'b0;
        send(HDR, 8'h0C);
        send(BODY, 8'h10);
        send(BODY, 8'h20);
        n_cmp++;
        if (bus.req_out !== 5'b00001) begin
            n_bad++;
            $display("FAIL areset_route: req=%b, want 00001", bus.req_out);
        end
        bus.grant_in = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.valid_out !== 1'b1 || bus.drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL areset_pre: valid=%b drop=%0d, want 1 and %0d", bus.valid_out, bus.drop_cnt, exp_drop);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_out !== 5'b0 || bus.valid_out !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL areset_clear: req=%b valid=%b drop=%0d, want 00000 0 0", bus.req_out, bus.valid_out, bus.drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.grant_in = 1'b0;
        exp_drop = 0;
        n_cmp++;
        if (bus.ready_out !== 1'b1 || bus.hdr_to_rc !== 8'h00) begin
            n_bad++;
            $display("FAIL areset_release: ready=%b hdr_to_rc=%h, want 1 and 00", bus.ready_out, bus.hdr_to_rc);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [9:0]  in_q [$];
        logic [14:0] exp_q [$];
        logic [4:0]  last_req = 5'b0;
        int cyc = 0;
        int extra = 0;
        for (int p = 0; p < 40; p++) begin
            logic [7:0] h;
            logic [1:0] t;
            int nb;
            h = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: t = BODY;
                    1: t = TAIL;
                    default: t = 2'b11;
                endcase
                in_q.push_back({t, h});
                exp_drop++;
            end else begin
                logic ok;
                logic [4:0] r;
                r = rc_tab[h[3:0]];
                ok = $onehot(r);
                nb = $urandom_range(0, 3);
                in_q.push_back({HDR, h});
                if (ok) exp_q.push_back({r, HDR, h});
                else exp_drop++;
                for (int b = 0; b <= nb; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    t = b == nb ? TAIL : BODY;
                    in_q.push_back({t, d});
                    if (ok) exp_q.push_back({r, t, d});
                    else exp_drop++;
                end
            end
        end
        while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 3000) begin
            if (bus.valid_out === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra: flit=%h type=%b, want no flit", bus.flit_out, bus.type_out);
                end else begin
                    if ({last_req, bus.type_out, bus.flit_out} !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL rand_flit: req=%b type=%b flit=%h, want req=%b type=%b flit=%h",
                                 last_req, bus.type_out, bus.flit_out, exp_q[0][14:10], exp_q[0][9:8], exp_q[0][7:0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            last_req = bus.req_out;
            bus.grant_in = 1'($urandom_range(0, 1));
            if (in_q.size() != 0) begin
                bus.valid_in = $urandom_range(0, 3) != 0;
                {bus.type_in, bus.flit_in} = in_q[0];
                if (bus.valid_in && bus.ready_out) void'(in_q.pop_front());
            end else begin
                bus.valid_in = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || in_q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_timeout: pending_out=%0d pending_in=%0d after %0d cycles, want 0 and 0",
                     exp_q.size(), in_q.size(), cyc);
        end
        bus.valid_in = 1'b0;
        bus.grant_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) extra++;
        end
        bus.grant_in = 1'b0;
        if (exp_drop > 255) exp_drop = 255;
        n_cmp++;
        if (extra != 0 || bus.drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL rand_end: extra=%0d drop=%0d, want 0 and %0d", extra, bus.drop_cnt, exp_drop);
        end
    endtask

    task automatic test_saturate();
        int seen_valid = 0;
        bus.grant_in = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, TAIL, 8'(i));
            @(negedge clk);
            if (bus.valid_out === 1'b1) seen_valid++;
        end
        drive(1'b0, BODY, 8'h00);
        repeat (4) @(negedge clk);
        bus.grant_in = 1'b0;
        exp_drop = exp_drop + 260 > 255 ? 255 : exp_drop + 260;
        n_cmp++;
        if (bus.drop_cnt !== 8'(exp_drop) || seen_valid != 0) begin
            n_bad++;
            $display("FAIL saturate: drop=%0d forwarded=%0d, want %0d and 0", bus.drop_cnt, seen_valid, exp_drop);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            case ($urandom_range(0, 5))
                0: rc_tab[i] = 5'b00000;
                1: rc_tab[i] = 5'b10100;
                default: rc_tab[i] = 5'b00001 << $urandom_range(0, 4);
            endcase
        rc_tab[12] = 5'b00001;
        rc_tab[10] = 5'b00010;
        rc_tab[8]  = 5'b00000;
        test_reset();
        test_basic();
        test_hold();
        test_drop();
        test_orphan();
        test_full();
        test_async_reset();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
